seg_scan_scheduler: RTL and testbench

SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

---
 rtl/seg_scan_scheduler.sv | 161 ++++++++++++++++
 tb/tb_seg_scan_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_scheduler.sv
// Four-digit seven-segment scanner with debounced per-digit load buttons.
// Button presses queue load requests serviced lowest index first, independent of the scan.
module seg_scan_scheduler #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned DWELL_CYCLES    = 65536,
   parameter int unsigned BLANK_CYCLES    = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] switches,
   input  logic [3:0] pushbtns,
   output logic [3:0] led,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       load_pulse,
   output logic [1:0] load_idx
);

   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int unsigned CW  = $clog2(CMAX + 1);

   typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

   logic [3:0]     sync1, sync2, deb, pending;
   logic [DBW-1:0] db_cnt [4];
   logic [3:0]     digit  [4];
   logic [3:0]     accept_c, press_c, svc_mask_c;
   logic [1:0]     svc_idx_c;
   logic           svc_valid_c;

   state_t         state, state_nxt;
   logic [1:0]     k, k_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b1111111;
      endcase
   endfunction

   // Debounce acceptance and press (0->1) detection
   always_comb begin
      accept_c = '0;
      press_c  = '0;
      for (int i = 0; i < 4; i++) begin
         accept_c[i] = (sync2[i] != deb[i]) && (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1));
         press_c[i]  = accept_c[i] & sync2[i];
      end
   end

   // Lowest-index pending request wins
   always_comb begin
      svc_mask_c  = '0;
      svc_idx_c   = '0;
      svc_valid_c = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (pending[i]) begin
            svc_mask_c  = 4'(1 << i);
            svc_idx_c   = 2'(i);
            svc_valid_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= '0;
         sync2   <= '0;
         deb     <= '0;
         pending <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
            digit[i]  <= 4'hF;
         end
         led        <= '0;
         load_pulse <= 1'b0;
         load_idx   <= '0;
      end else begin
         sync1 <= pushbtns;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (accept_c[i]) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DBW'(1);
            end
         end
         pending <= (pending & ~svc_mask_c) | press_c;
         if (svc_valid_c) begin
            digit[svc_idx_c] <= (switches > 4'd9) ? 4'hF : switches;
         end
         led        <= (switches > 4'd9) ? 4'd0 : switches;
         load_pulse <= svc_valid_c;
         load_idx   <= svc_idx_c;
      end
   end

   // Scan FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_BLANK;
         k     <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Pointer advances on leaving DRIVE so reset's blank phase leads into digit 0
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      cnt_nxt   = cnt + CW'(1);
      case (state)
         ST_DRIVE: begin
            if (cnt == CW'(DWELL_CYCLES - 1)) begin
               cnt_nxt   = '0;
               k_nxt     = k + 2'd1;
               state_nxt = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
            end
         end
         default: begin
            if ((BLANK_CYCLES == 0) || (cnt == CW'(BLANK_CYCLES - 1))) begin
               cnt_nxt   = '0;
               state_nxt = ST_DRIVE;
            end
         end
      endcase
   end

   // Display outputs trail the FSM by one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= 7'b1111111;
         an  <= 4'b1111;
      end else if (state == ST_DRIVE) begin
         seg <= decode(digit[k]);
         an  <= ~(4'b1000 >> k);
      end else begin
         seg <= 7'b1111111;
         an  <= 4'b1111;
      end
   end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Scoreboard bench for seg_scan_scheduler: queued load expectations plus a per-cycle display monitor.
module tb_seg_scan_scheduler;

   localparam int unsigned DEB   = 4;
   localparam int unsigned DWELL = 8;
   localparam int unsigned BLANK = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] switches;
   logic [3:0] pushbtns;
   logic [3:0] led;
   logic [6:0] seg;
   logic [3:0] an;
   logic       load_pulse;
   logic [1:0] load_idx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] idx;
      logic [3:0] val;
   } load_t;
   load_t exp_q[$];

   logic [3:0] mdig [4];
   bit         m_blank;
   int         m_k, m_cnt;
   logic [6:0] exp_seg;
   logic [3:0] exp_an;
   logic       rst_at_edge = 1'b0;

   seg_scan_scheduler #(
      .DEBOUNCE_CYCLES(DEB),
      .DWELL_CYCLES   (DWELL),
      .BLANK_CYCLES   (BLANK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .switches  (switches),
      .pushbtns  (pushbtns),
      .led       (led),
      .seg       (seg),
      .an        (an),
      .load_pulse(load_pulse),
      .load_idx  (load_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0:    dec = 7'b1000000;
         4'd1:    dec = 7'b1111001;
         4'd2:    dec = 7'b0100100;
         4'd3:    dec = 7'b0110000;
         4'd4:    dec = 7'b0011001;
         4'd5:    dec = 7'b0010010;
         4'd6:    dec = 7'b0000010;
         4'd7:    dec = 7'b1111000;
         4'd8:    dec = 7'b0000000;
         4'd9:    dec = 7'b0010000;
         default: dec = 7'b1111111;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) rst_at_edge <= rst_n;

   // Monitor: scan reference, load scoreboard pop, display comparison
   always @(negedge clk) begin
      if (!rst_n) begin
         m_blank = 1'b1;
         m_k     = 0;
         m_cnt   = 0;
         for (int i = 0; i < 4; i++) mdig[i] = 4'hF;
         check("rst_seg", 32'(seg), 32'h7F);
         check("rst_an", 32'(an), 32'hF);
         check("rst_load_pulse", 32'(load_pulse), 32'h0);
         exp_seg = 7'b1111111;
         exp_an  = 4'b1111;
      end else begin
         if (rst_at_edge) begin
            if (m_blank) begin
               if (m_cnt == int'(BLANK) - 1) begin
                  m_blank = 1'b0;
                  m_cnt   = 0;
               end else m_cnt++;
            end else if (m_cnt == int'(DWELL) - 1) begin
               m_cnt   = 0;
               m_k     = (m_k + 1) % 4;
               m_blank = 1'b1;
            end else m_cnt++;
         end
         if (load_pulse) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_load: got load_idx %0d expected no load at %0t", load_idx, $time);
            end else begin
               load_t e;
               e = exp_q.pop_front();
               check("load_idx", 32'(load_idx), 32'(e.idx));
               mdig[e.idx] = e.val;
            end
         end
         check("scan_an", 32'(an), 32'(exp_an));
         check("scan_seg", 32'(seg), 32'(exp_seg));
         exp_an  = m_blank ? 4'b1111 : ~(4'b1000 >> m_k);
         exp_seg = m_blank ? 7'b1111111 : dec(mdig[m_k]);
      end
   end

   task automatic press(input logic [3:0] mask, input int hold);
      @(posedge clk); #2;
      pushbtns = mask;
      repeat (hold) @(posedge clk);
      #2 pushbtns = 4'h0;
      repeat (12) @(posedge clk);
   endtask

   task automatic wait_an(input logic [3:0] target, input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 60 && !seen; n++) begin
         @(negedge clk);
         if (an == target) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: an never reached %b", name, target);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      switches = 4'h0;
      pushbtns = 4'h0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Idle scan: two full periods, all blank
      repeat (85) @(posedge clk);

      // Load 5 into digit 2
      #2 switches = 4'd5;
      repeat (2) @(posedge clk);
      #1 check("led_5", 32'(led), 32'd5);
      exp_q.push_back('{idx: 2'd2, val: 4'd5});
      press(4'b0100, 10);
      wait_an(4'b1101, "digit2");
      check("digit2_seg", 32'(seg), 32'b0010010);
      repeat (45) @(posedge clk);

      // Bouncing button 1: never stable long enough
      for (int t = 0; t < 10; t++) begin
         @(posedge clk); #2 pushbtns[1] = ~pushbtns[1];
         @(posedge clk);
      end
      #2 pushbtns = 4'h0;
      repeat (45) @(posedge clk);
      wait_an(4'b1011, "digit1");
      check("digit1_blank", 32'(seg), 32'h7F);

      // Simultaneous press of digits 0, 1, 3
      #2 switches = 4'd7;
      exp_q.push_back('{idx: 2'd0, val: 4'd7});
      exp_q.push_back('{idx: 2'd1, val: 4'd7});
      exp_q.push_back('{idx: 2'd3, val: 4'd7});
      press(4'b1011, 10);
      wait_an(4'b1110, "digit3");
      check("digit3_seg", 32'(seg), 32'b1111000);
      repeat (45) @(posedge clk);

      // Out-of-range value blanks digit 0
      #2 switches = 4'd12;
      repeat (2) @(posedge clk);
      #1 check("led_12", 32'(led), 32'd0);
      exp_q.push_back('{idx: 2'd0, val: 4'hF});
      press(4'b0001, 10);
      wait_an(4'b0111, "digit0");
      check("digit0_blank", 32'(seg), 32'h7F);
      repeat (45) @(posedge clk);

      // Asynchronous reset mid-DRIVE
      wait_an(4'b1110, "drive_before_reset");
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("async_rst_an", 32'(an), 32'hF);
      check("async_rst_seg", 32'(seg), 32'h7F);
      check("async_rst_led", 32'(led), 32'h0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (85) @(posedge clk);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_loads: got %0d outstanding expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
